bird_collision: RTL and testbench

- Consumer end of the pipe position interface.
- Each cycle it samples the pipe position (PipePosXA/PipePosYA) produced by the pipe mover, together with the bird's vertical position.
- It detects bird/pipe and bird/floor collisions, counts pipes cleared, and raises Lost for the top-level game FSM and the display.
- It sits between the pipe mover, the bird physics block and the VGA/score renderer.

---
 rtl/flappy_pkg.sv | 21 ++
 rtl/pipe_hit_geom.sv | 53 +++++
 rtl/bird_collision.sv | 96 +++++++++
 tb/tb_bird_collision.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared geometry and FSM encoding for the flappy-bird collision logic.
// All geometry is in screen pixels.
package flappy_pkg;

  localparam int unsigned BIRD_X        = 200;
  localparam int unsigned BIRD_SIZE     = 20;
  localparam int unsigned PIPE_W        = 60;
  localparam int unsigned GAP_H         = 150;
  localparam int unsigned SCREEN_H      = 480;
  localparam int unsigned PIPE_RELOAD_X = 1000;

  // Geometry sums need 11 bits: PIPE_RELOAD_X + PIPE_W reaches 1060.
  localparam int unsigned GEOM_W = 11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'b001;
  localparam state_t S_PLAY = 3'b010;
  localparam state_t S_LOST = 3'b100;

endpackage

// File: rtl/pipe_hit_geom.sv
// Combinational bird/pipe/floor geometry.
// Yields the hit and cleared flags for the current pipe position.
module pipe_hit_geom
  import flappy_pkg::*;
#(
  parameter int unsigned BirdX    = BIRD_X,
  parameter int unsigned BirdSize = BIRD_SIZE,
  parameter int unsigned PipeW    = PIPE_W,
  parameter int unsigned GapH     = GAP_H,
  parameter int unsigned ScreenH  = SCREEN_H
) (
  input  logic [9:0] bird_y_i,
  input  logic [9:0] pipe_x_i,
  input  logic [9:0] pipe_y_i,
  output logic       hit_o,
  output logic       cleared_o
);

  localparam logic [GEOM_W-1:0] BirdLeft  = GEOM_W'(BirdX);
  localparam logic [GEOM_W-1:0] BirdRight = GEOM_W'(BirdX + BirdSize);
  localparam logic [GEOM_W-1:0] SizeW     = GEOM_W'(BirdSize);
  localparam logic [GEOM_W-1:0] PipeWW    = GEOM_W'(PipeW);
  localparam logic [GEOM_W-1:0] GapW      = GEOM_W'(GapH);
  localparam logic [GEOM_W-1:0] FloorW    = GEOM_W'(ScreenH);

  logic [GEOM_W-1:0] bird_top;
  logic [GEOM_W-1:0] bird_bot;
  logic [GEOM_W-1:0] pipe_left;
  logic [GEOM_W-1:0] pipe_right;
  logic [GEOM_W-1:0] gap_top;
  logic [GEOM_W-1:0] gap_bot;
  logic              overlap;
  logic              gap_safe;
  logic              floor_hit;

  always_comb begin
    bird_top   = {1'b0, bird_y_i};
    bird_bot   = bird_top + SizeW;
    pipe_left  = {1'b0, pipe_x_i};
    pipe_right = pipe_left + PipeWW;
    gap_top    = {1'b0, pipe_y_i};
    gap_bot    = gap_top + GapW;

    overlap   = (pipe_left < BirdRight) && (pipe_right > BirdLeft);
    gap_safe  = (bird_top >= gap_top) && (bird_bot <= gap_bot);
    // Only the floor kills; the bird may leave through the top of the screen.
    floor_hit = (bird_bot >= FloorW);

    hit_o     = (overlap && !gap_safe) || floor_hit;
    cleared_o = (pipe_right <= BirdLeft);
  end

endmodule

// File: rtl/bird_collision.sv
// Game-state tracker: detects collisions, counts cleared pipes and reports
// PLAY/LOST to the game FSM and renderer through one registered stage.
module bird_collision
  import flappy_pkg::*;
#(
  parameter int unsigned BirdX    = BIRD_X,
  parameter int unsigned BirdSize = BIRD_SIZE,
  parameter int unsigned PipeW    = PIPE_W,
  parameter int unsigned GapH     = GAP_H,
  parameter int unsigned ScreenH  = SCREEN_H,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [9:0]         BirdPosY,
  input  logic [9:0]         PipePosXA,
  input  logic [9:0]         PipePosYA,
  output logic               Lost,
  output logic               Playing,
  output logic [SCORE_W-1:0] Score
);

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 armed_q, armed_d;
  logic                 hit;
  logic                 cleared;

  pipe_hit_geom #(
    .BirdX    (BirdX),
    .BirdSize (BirdSize),
    .PipeW    (PipeW),
    .GapH     (GapH),
    .ScreenH  (ScreenH)
  ) u_geom (
    .bird_y_i  (BirdPosY),
    .pipe_x_i  (PipePosXA),
    .pipe_y_i  (PipePosYA),
    .hit_o     (hit),
    .cleared_o (cleared)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    armed_d = armed_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_PLAY;
          score_d = '0;
          armed_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A hit on the same cycle as a clear still ends the game unscored.
        if (hit) begin
          state_d = S_LOST;
        end else if (!cleared) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
      end
      S_LOST: begin
        if (!Start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      score_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      armed_q <= armed_d;
    end
  end

  assign Lost    = (state_q == S_LOST);
  assign Playing = (state_q == S_PLAY);
  assign Score   = score_q;

endmodule

// File: tb/tb_bird_collision.sv
// Directed self-checking bench for bird_collision.
module tb_bird_collision;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] bird_y;
  logic [9:0] pipe_x;
  logic [9:0] pipe_y;
  logic       lost;
  logic       playing;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;

  bird_collision dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .BirdPosY  (bird_y),
    .PipePosXA (pipe_x),
    .PipePosYA (pipe_y),
    .Lost      (lost),
    .Playing   (playing),
    .Score     (score)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic safe_inputs();
    bird_y = 10'd200;
    pipe_y = 10'd190;
    pipe_x = 10'd1000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    safe_inputs();
    tick();
    tick();
    total++;
    if ({lost, playing, score} !== 10'd0) begin
      $display("FAIL reset_state lost=%b playing=%b score=%0d want 0/0/0", lost, playing, score);
      bad++;
    end
    reset = 1'b0;
    tick();
    total++;
    if (playing !== 1'b1 || lost !== 1'b0) begin
      $display("FAIL reset_release playing=%b lost=%b want 1/0", playing, lost);
      bad++;
    end
  endtask

  task automatic test_sweep();
    int xs[10]  = '{300, 250, 210, 200, 150, 141, 140, 100, 60, 0};
    int exp[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        pipe_x = 10'(xs[i]);
        tick();
        total++;
        if (lost !== 1'b0 || score !== 8'(exp[i] + pass)) begin
          $display("FAIL sweep pass=%0d x=%0d lost=%b score=%0d want 0/%0d",
                   pass, xs[i], lost, score, exp[i] + pass);
          bad++;
        end
      end
      pipe_x = 10'd1000;
      tick();
    end
    total++;
    if (score !== 8'd2) begin
      $display("FAIL sweep_total score=%0d want 2", score);
      bad++;
    end
  endtask

  task automatic test_pipe_hit();
    bird_y = 10'd100;
    pipe_y = 10'd190;
    pipe_x = 10'd210;
    tick();
    total++;
    if (lost !== 1'b1 || playing !== 1'b0) begin
      $display("FAIL pipe_hit lost=%b playing=%b want 1/0", lost, playing);
      bad++;
    end
    tick();
    tick();
    total++;
    if (lost !== 1'b1 || score !== 8'd2) begin
      $display("FAIL lost_hold lost=%b score=%0d want 1/2", lost, score);
      bad++;
    end
    start = 1'b0;
    safe_inputs();
    tick();
    total++;
    if (lost !== 1'b0 || playing !== 1'b0 || score !== 8'd2) begin
      $display("FAIL to_idle lost=%b playing=%b score=%0d want 0/0/2", lost, playing, score);
      bad++;
    end
    start = 1'b1;
    tick();
    total++;
    if (playing !== 1'b1 || score !== 8'd0) begin
      $display("FAIL restart playing=%b score=%0d want 1/0", playing, score);
      bad++;
    end
  endtask

  task automatic test_floor();
    pipe_x = 10'd1000;
    bird_y = 10'd459;
    tick();
    tick();
    total++;
    if (lost !== 1'b0 || playing !== 1'b1) begin
      $display("FAIL floor_459 lost=%b playing=%b want 0/1", lost, playing);
      bad++;
    end
    bird_y = 10'd460;
    tick();
    total++;
    if (lost !== 1'b1) begin
      $display("FAIL floor_460 lost=%b want 1", lost);
      bad++;
    end
  endtask

  task automatic restart_from_lost();
    start = 1'b0;
    safe_inputs();
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic clear_pipes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_x = 10'd100;
      tick();
      pipe_x = 10'd1000;
      tick();
    end
  endtask

  task automatic test_hit_wins_and_saturation();
    restart_from_lost();
    clear_pipes(5);
    total++;
    if (score !== 8'd5) begin
      $display("FAIL five_clears score=%0d want 5", score);
      bad++;
    end
    pipe_x = 10'd100;
    bird_y = 10'd460;
    tick();
    total++;
    if (lost !== 1'b1 || score !== 8'd5) begin
      $display("FAIL hit_wins lost=%b score=%0d want 1/5", lost, score);
      bad++;
    end
    restart_from_lost();
    clear_pipes(255);
    total++;
    if (score !== 8'd255) begin
      $display("FAIL reach_255 score=%0d want 255", score);
      bad++;
    end
    clear_pipes(1);
    total++;
    if (score !== 8'd255 || playing !== 1'b1) begin
      $display("FAIL saturate score=%0d playing=%b want 255/1", score, playing);
      bad++;
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_pipes(3);
    total++;
    if (score !== 8'd3 || playing !== 1'b1) begin
      $display("FAIL pre_reset score=%0d playing=%b want 3/1", score, playing);
      bad++;
    end
    reset = 1'b1;
    tick();
    total++;
    if (score !== 8'd0 || lost !== 1'b0 || playing !== 1'b0) begin
      $display("FAIL mid_reset score=%0d lost=%b playing=%b want 0/0/0", score, lost, playing);
      bad++;
    end
    reset = 1'b0;
    tick();
    total++;
    if (playing !== 1'b1 || score !== 8'd0) begin
      $display("FAIL after_reset playing=%b score=%0d want 1/0", playing, score);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_pipe_hit();
    test_floor();
    test_hit_wins_and_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
